// File: rtl/uart_core.sv
// uart_core: 8N1 UART transmitter/receiver behind a small word-addressed register port.
// Define UART_CORE_IRQ_EN to build the receive interrupt flag (IRQ_event, register 0x2).
module uart_core #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic [3:0]  avms_address_i,
  input  logic [3:0]  avms_byteenable_i,
  input  logic        avms_read_i,
  input  logic        avms_write_i,
  input  logic [31:0] avms_writedata_i,
  output logic [31:0] avms_readdata_o,
  output logic        uart_txd_o,
  input  logic        uart_rxd_i,
  output logic        IRQ_event
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
`ifdef UART_CORE_IRQ_EN
  localparam logic [3:0] ADDR_IRQ    = 4'h2;
`endif

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Reset asserts asynchronously but is released in step with clk_i.
  logic rst_meta_q, rst_n_q;
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  logic             tx_busy_q, tx_busy_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [8:0]       tx_shift_q, tx_shift_d;
  logic             txd_q, txd_d;

  logic             rx_meta_q, rx_meta_d;
  logic             rx_sync_q, rx_sync_d;
  logic             rx_prev_q, rx_prev_d;
  logic [1:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [31:0]      rd_data_q, rd_data_d;
`ifdef UART_CORE_IRQ_EN
  logic             irq_q, irq_d;
`endif

  logic        tx_start, rd_data_clr, rd_stat_clr;
  logic        rx_done_ok, rx_done_bad;
  logic [31:0] rd_value;

  assign tx_start    = avms_write_i && (avms_address_i == ADDR_DATA) && !tx_busy_q;
  assign rd_data_clr = avms_read_i && (avms_address_i == ADDR_DATA);
  assign rd_stat_clr = avms_read_i && (avms_address_i == ADDR_STATUS);

  // NOTE: every _d gets a default at the top so no path through the block can infer a latch.
  always_comb begin
    tx_busy_d   = tx_busy_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    txd_d       = txd_q;
    rx_meta_d   = uart_rxd_i;
    rx_sync_d   = rx_meta_q;
    rx_prev_d   = rx_sync_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    rx_done_ok  = 1'b0;
    rx_done_bad = 1'b0;
    rd_value    = '0;

    // Transmitter: tx_bit_q counts start(0), data(1..8), stop(9).
    if (tx_busy_q) begin
      if (tx_cnt_q == DIV_M1) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
        end else begin
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[8:1]};
          tx_bit_d   = tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end else if (tx_start) begin
      txd_d      = 1'b0;
      tx_shift_d = {1'b1, avms_writedata_i[7:0]};
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_busy_d  = 1'b1;
    end

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: begin
        if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d    = '0;
          rx_state_d  = RX_IDLE;
          rx_done_ok  = rx_sync_q;
          rx_done_bad = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
    endcase

    case (avms_address_i)
      ADDR_DATA:   rd_value = {24'b0, rx_data_q};
      ADDR_STATUS: rd_value = {28'b0, overrun_q, frame_err_q, rx_valid_q, !tx_busy_q};
`ifdef UART_CORE_IRQ_EN
      ADDR_IRQ:    rd_value = {31'b0, irq_q};
`endif
      default:     rd_value = '0;
    endcase
    rd_data_d = avms_read_i ? rd_value : rd_data_q;

    // Read side effects apply first so a frame landing on the same edge is not lost.
    if (rd_data_clr) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (rd_stat_clr) frame_err_d = 1'b0;
    if (rx_done_ok) begin
      if (rx_valid_d) overrun_d = 1'b1;
      rx_valid_d = 1'b1;
      rx_data_d  = rx_shift_q;
    end
    if (rx_done_bad) frame_err_d = 1'b1;

`ifdef UART_CORE_IRQ_EN
    irq_d = irq_q;
    if ((avms_address_i == ADDR_IRQ) && avms_byteenable_i[0]) irq_d = 1'b0;
    if (rx_done_ok) irq_d = 1'b1;
`endif
  end

  // NOTE: state updates use non-blocking assignment so all flops sample pre-edge values together.
  always_ff @(posedge clk_i or negedge rst_n_q) begin
    if (!rst_n_q) begin
      tx_busy_q   <= 1'b0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      txd_q       <= 1'b1;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rd_data_q   <= '0;
`ifdef UART_CORE_IRQ_EN
      irq_q       <= 1'b0;
`endif
    end else begin
      tx_busy_q   <= tx_busy_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      txd_q       <= txd_d;
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rd_data_q   <= rd_data_d;
`ifdef UART_CORE_IRQ_EN
      irq_q       <= irq_d;
`endif
    end
  end

  assign avms_readdata_o = rd_data_q;
  assign uart_txd_o      = txd_q;
`ifdef UART_CORE_IRQ_EN
  assign IRQ_event = irq_q;
`else
  assign IRQ_event = 1'b0;
`endif

  // Byte enables only matter for the IRQ acknowledge; upper write data is don't-care.
  logic unused_inputs;
  assign unused_inputs = ^{avms_byteenable_i, avms_writedata_i[31:8]};

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: randomized self-checking bench for uart_core against a register-level model.
// Interrupt expectations follow UART_CORE_IRQ_EN, matching the DUT build.
module tb_uart_core;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 57_600;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_CORE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk, arst_n;
  logic [3:0]  addr, be;
  logic        rd, wr;
  logic [31:0] wdata, rdata;
  logic        txd, rxd, irq;

  uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .avms_address_i(addr), .avms_byteenable_i(be),
    .avms_read_i(rd), .avms_write_i(wr),
    .avms_writedata_i(wdata), .avms_readdata_o(rdata),
    .uart_txd_o(txd), .uart_rxd_i(rxd), .IRQ_event(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit bus_busy = 1'b0;
  bit mon_en = 1'b0;
  logic [9:0] tx_q[$];

  logic [7:0] m_rxdata = 8'h00;
  bit m_valid = 0, m_ovr = 0, m_ferr = 0, m_irq = 0, m_txrdy = 1;

  logic [7:0] tx_bytes [12] = '{8'h48, 8'h45, 8'h4C, 8'h89, 8'h4F, 8'h5F,
                                8'h57, 8'h66, 8'h52, 8'h99, 8'h44, 8'h21};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bus operations start at a negedge and return one negedge later.
  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    while (bus_busy) @(negedge clk);
    bus_busy = 1'b1;
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = rdata;
    bus_busy = 1'b0;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    while (bus_busy) @(negedge clk);
    bus_busy = 1'b1;
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    bus_busy = 1'b0;
  endtask

  task automatic irq_ack();
    while (bus_busy) @(negedge clk);
    bus_busy = 1'b1;
    addr = 4'h2; be = 4'h1;
    @(negedge clk);
    be = 4'h0;
    bus_busy = 1'b0;
    m_irq = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] r;
    case (a)
      4'h0: begin r = {24'b0, m_rxdata}; m_valid = 0; m_ovr = 0; end
      4'h1: begin r = {28'b0, m_ovr, m_ferr, m_valid, m_txrdy}; m_ferr = 0; end
      4'h2: r = {31'b0, IRQ_EN & m_irq};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic void model_rx_frame(input logic [7:0] b, input bit ok);
    if (ok) begin
      if (m_valid) m_ovr = 1;
      m_valid = 1; m_rxdata = b; m_irq = 1;
    end else begin
      m_ferr = 1;
    end
  endfunction

  task automatic rd_check(input string tag, input logic [3:0] a);
    logic [31:0] d;
    bus_rd(a, d);
    check(tag, d, model_read(a));
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop_bit);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Line decoder: samples each transmitted frame at its bit centres.
  initial begin
    logic [9:0] fr;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        fr[0] = txd;
        for (int i = 1; i < 10; i++) begin
          repeat (DIV) @(negedge clk);
          fr[i] = txd;
        end
        tx_q.push_back(fr);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st;
    logic [9:0]  fr_exp;
    addr = '0; be = '0; rd = 0; wr = 0; wdata = '0; rxd = 1'b1;
    arst_n = 1'b1;
    #1 arst_n = 1'b0;
    repeat (4) @(negedge clk);
    arst_n = 1'b1;
    repeat (4) @(negedge clk);
    mon_en = 1'b1;

    check("rst_txd", txd, 1);
    check("rst_irq", irq, 0);
    check("rst_readdata", rdata, 0);
    rd_check("rst_status", 4'h1);
    rd_check("rst_rxdata", 4'h0);
    rd_check("unmapped_5", 4'h5);
    rd_check("unmapped_f", 4'hF);
    bus_wr(4'h3, 32'h55);
    repeat (3) @(negedge clk);
    check("unmapped_wr_txd", txd, 1);
    rd_check("unmapped_wr_status", 4'h1);

    // Bit-exact transmit of 0x48 with a discarded mid-frame write.
    fr_exp = {1'b1, 8'h48, 1'b0};
    bus_wr(4'h0, 32'h48);
    for (int k = 0; k < 10; k++) begin
      check("tx_bit_begin", txd, fr_exp[k]);
      if (k == 4) begin
        bus_wr(4'h0, 32'h45);
        bus_rd(4'h1, st);
        check("tx_busy_status", st, 0);
        repeat (DIV - 3) @(negedge clk);
      end else if (k == 9) begin
        repeat (DIV - 2) @(negedge clk);
        bus_rd(4'h1, st);
        check("tx_last_cycle_status", st, 0);
      end else begin
        repeat (DIV - 1) @(negedge clk);
      end
      check("tx_bit_end", txd, fr_exp[k]);
      @(negedge clk);
    end
    rd_check("tx_done_status", 4'h1);
    repeat (12 * DIV) @(negedge clk);
    check("tx_frame_count", tx_q.size(), 1);
    check("tx_frame_value", (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hFFFF_FFFF, {22'b0, fr_exp});
    tx_q.delete();

    // Single receive, read-back and interrupt acknowledge.
    send_rx(8'h0A, 1'b1); model_rx_frame(8'h0A, 1'b1);
    check("rx_irq_set", irq, IRQ_EN & m_irq);
    rd_check("rx_status_valid", 4'h1);
    rd_check("rx_data_0a", 4'h0);
    rd_check("rx_status_cleared", 4'h1);
    rd_check("rx_irq_reg", 4'h2);
    check("rx_irq_held", irq, IRQ_EN & m_irq);
    irq_ack();
    check("rx_irq_acked", irq, 0);
    rd_check("rx_irq_reg_acked", 4'h2);

    // Overrun, then a framing error.
    send_rx(8'h0B, 1'b1); model_rx_frame(8'h0B, 1'b1);
    send_rx(8'h0C, 1'b1); model_rx_frame(8'h0C, 1'b1);
    rd_check("ovr_status", 4'h1);
    rd_check("ovr_data", 4'h0);
    irq_ack();
    send_rx(8'h5A, 1'b0); model_rx_frame(8'h5A, 1'b0);
    check("ferr_no_irq", irq, 0);
    rd_check("ferr_status", 4'h1);
    rd_check("ferr_status_cleared", 4'h1);
    rd_check("ferr_data_kept", 4'h0);

    // Short low glitch must be rejected.
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    rd_check("glitch_status", 4'h1);
    check("glitch_irq", irq, 0);

    // Randomized frames, glitches and register actions.
    for (int it = 0; it < 10; it++) begin
      logic [7:0] rb;
      bit ok;
      rb = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        rxd = 1'b0;
        repeat ($urandom_range(1, DIV / 2 - 3)) @(negedge clk);
        rxd = 1'b1;
        repeat (DIV) @(negedge clk);
      end
      send_rx(rb, ok); model_rx_frame(rb, ok);
      repeat ($urandom_range(1, DIV)) @(negedge clk);
      check("rnd_irq", irq, IRQ_EN & m_irq);
      case ($urandom_range(0, 3))
        0: rd_check("rnd_data", 4'h0);
        1: rd_check("rnd_irq_reg", 4'h2);
        2: irq_ack();
        default: ;
      endcase
      rd_check("rnd_status", 4'h1);
    end
    irq_ack();
    rd_check("pre_cc_data", 4'h0);

    // Concurrent transmit of 12 bytes and receive of 0x0A..0x13.
    fork
      begin
        logic [31:0] pst;
        int tries;
        for (int i = 0; i < 12; i++) begin
          tries = 0;
          do begin
            bus_rd(4'h1, pst);
            if (!pst[0]) repeat (3) @(negedge clk);
            tries++;
          end while (!pst[0] && tries < 300);
          if (!pst[0]) check("cc_tx_poll_timeout", pst[0], 1);
          bus_wr(4'h0, {24'b0, tx_bytes[i]});
          @(negedge clk);
        end
      end
      begin
        for (int b = 8'h0A; b <= 8'h13; b++) begin
          send_rx(8'(b), 1'b1); model_rx_frame(8'(b), 1'b1);
          rd_check("cc_rxdata", 4'h0);
        end
      end
    join
    repeat (12 * DIV) @(negedge clk);
    rd_check("cc_status", 4'h1);
    check("cc_tx_count", tx_q.size(), 12);
    for (int i = 0; i < 12; i++)
      check("cc_tx_frame", (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hFFFF_FFFF,
            {22'b0, 1'b1, tx_bytes[i], 1'b0});
    irq_ack();

    // Reset in the middle of both a transmit and a receive frame.
    rd_check("pre_rst_data", 4'h0);
    bus_wr(4'h0, 32'hA5);
    rxd = 1'b0; repeat (DIV) @(negedge clk);
    rxd = 1'b1; repeat (DIV) @(negedge clk);
    rxd = 1'b0; repeat (DIV) @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    check("midrst_txd", txd, 1);
    check("midrst_irq", irq, 0);
    check("midrst_readdata", rdata, 0);
    rxd = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    repeat (5) @(negedge clk);
    m_rxdata = 8'h00; m_valid = 0; m_ovr = 0; m_ferr = 0; m_irq = 0; m_txrdy = 1;
    check("postrst_txd", txd, 1);
    rd_check("postrst_status", 4'h1);
    rd_check("postrst_data", 4'h0);
    rd_check("postrst_irq_reg", 4'h2);
    repeat (12 * DIV) @(negedge clk);
    tx_q.delete();
    check("postrst_txd_idle", txd, 1);
    rd_check("postrst_status_idle", 4'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate.
REQ-003 SHALL have one clock and an asynchronous active-low reset:
- clk_i  in  1  system clock, rising edge
- arst_n_i  in  1  asynchronous active-low reset
REQ-004 SHALL have the following bus and serial ports:
- avms_address_i  in  4  register word address
- avms_byteenable_i  in  4  byte lanes; bit0 used for IRQ acknowledge only
- avms_read_i  in  1  read strobe
- avms_write_i  in  1  write strobe
- avms_writedata_i  in  32  write data
- avms_readdata_o  out  32  read data
- uart_txd_o  out  1  serial transmit, idle high
- uart_rxd_i  in  1  serial receive, asynchronous
- IRQ_event  out  1  receive interrupt, active high, level

Function
REQ-005 SHALL use bit period DIV = CLK_FREQ/BAUD_RATE clocks, integer-truncated; 868 at defaults.
REQ-006 SHALL use 8N1 framing: start bit 0, 8 data bits LSB first, one stop bit 1.
REQ-007 SHALL implement this register map; unmapped addresses read 0 and ignore writes:
- 0x0: write = TXDATA[7:0]; read = RXDATA[7:0], upper bits 0
- 0x1: read STATUS, with bit0 TX_READY, bit1 RX_VALID, bit2 FRAME_ERR, bit3 OVERRUN, others 0
- 0x2: read bit0 = IRQ pending
REQ-008 SHALL register avms_readdata_o on the rising edge where avms_read_i=1, giving valid data after that edge; it holds its value when no read occurs.
REQ-009 SHALL ignore avms_byteenable_i for writes and reads.
REQ-010 A write to 0x0 while TX_READY=1 SHALL latch writedata[7:0], clear TX_READY on the next edge, and start the start bit on uart_txd_o within 1 clock.
REQ-011 A write to 0x0 while TX_READY=0 SHALL be discarded; an in-flight frame is never disturbed.
REQ-012 The transmitter SHALL hold each bit for exactly DIV clocks and set TX_READY when the stop bit period ends; a frame lasts 10*DIV clocks.
REQ-013 uart_rxd_i SHALL pass through a 2-flop synchronizer.
REQ-014 The receiver SHALL use states IDLE, START, DATA, STOP, with these transitions:
- IDLE to START on a synchronized falling edge.
- START checks the line at DIV/2; if it is high, the receiver returns to IDLE (glitch rejection).
- DATA samples 8 bits at bit centres, DIV apart.
- STOP samples at its centre, then returns to IDLE.
REQ-015 If the stop bit is 1, the receiver SHALL:
- load RXDATA
- set RX_VALID
- set IRQ pending
- set OVERRUN if RX_VALID was already 1, and overwrite RXDATA
REQ-016 If the stop bit is 0, the receiver SHALL set FRAME_ERR and discard the data, leaving RXDATA, RX_VALID and IRQ unchanged.
REQ-017 A read of 0x0 SHALL clear RX_VALID and OVERRUN; a read of 0x1 SHALL clear FRAME_ERR, after the read data is captured.
REQ-018 IRQ pending SHALL be cleared on any edge with avms_address_i=0x2 and avms_byteenable_i[0]=1, with no strobe required.
REQ-019 If IRQ set and IRQ clear occur on the same edge, set SHALL win.
REQ-020 Transmitter and receiver SHALL operate fully independently and concurrently.

Reset
REQ-021 On arst_n_i low, the block SHALL immediately apply these values:
- uart_txd_o=1
- IRQ_event=0
- avms_readdata_o=0
- TX_READY=1, RX_VALID=0, FRAME_ERR=0, OVERRUN=0
- RXDATA=0
- both state machines in IDLE with counters 0
REQ-022 Reset asserted mid-frame SHALL abort the frame with no partial data retained; release is synchronous to clk_i.

Configuration
REQ-023 Macro UART_CORE_IRQ_EN SHALL control the interrupt logic:
- Defined: IRQ_event is driven by IRQ pending per REQ-015/018/019.
- Undefined: the IRQ flag logic is omitted, IRQ_event is tied 0, and address 0x2 reads 0.

Verification
REQ-024 Reset, then read 0x1 -> readdata=0x00000001; uart_txd_o=1.
REQ-025 Write 0x48 to 0x0 -> on uart_txd_o: 0, then 0,0,0,1,0,0,1,0, then 1, each DIV clocks; TX_READY=0 during the frame and 1 after 10*DIV.
REQ-026 Second write (0x45) mid-frame -> ignored; only 0x48 is transmitted.
REQ-027 Drive rxd frame 0x0A, LSB first, at 868 clocks/bit -> IRQ_event=1 and STATUS=0x2 (TX idle adds bit0). Then:
- read 0x0 -> 0x0000000A, RX_VALID=0
- address=0x2 with byteenable=1 for 1 clock -> IRQ_event=0
REQ-028 Two frames (0x0B, 0x0C) without reading -> OVERRUN=1 and RXDATA=0x0C; rxd held low through the stop bit -> FRAME_ERR=1, and no IRQ.
REQ-029 Continuous TX of the 12 bytes 48 45 4C 89 4F 5F 57 66 52 99 44 21, polled via TX_READY, concurrent with RX of bytes 0x0A..0x13 -> all bytes exact, with no lost or corrupted frames.
